// File: rtl/bp_pht_arbiter.sv
// Pattern history table of 2-bit saturating counters. A single table access
// slot per cycle is shared between fetch-side lookups and queued resolve-side
// updates; after reset an init sweep writes weakly-not-taken to every entry.
//
// Handshakes: a transfer happens on a port in exactly the cycle where its
// valid and ready are both high. lk_ready and up_ready are functions of
// internal state only (never of the valid inputs), and a requester may hold
// or change its request freely while ready is low.

package bp_pkg;
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } state_t;
endpackage

module bp_pht_arbiter #(
  parameter int IDX_W      = 4,
  parameter int UQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8,
  localparam int CNT_W     = $clog2(UQ_DEPTH + 1),
  localparam int SC_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lk_valid,
  output logic             lk_ready,
  input  logic [IDX_W-1:0] lk_idx,
  output logic             pred_valid,
  output logic [1:0]       pred_state,
  output logic             pred_taken,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_taken,
  output logic             init_done,
  output logic [CNT_W-1:0] uq_count,
  output logic             dbg_state,
  output logic [SC_W-1:0]  dbg_starve_cnt
);
  import bp_pkg::*;

  localparam int ENTRIES = 1 << IDX_W;
  localparam int PTR_W   = (UQ_DEPTH > 1) ? $clog2(UQ_DEPTH) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(UQ_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(UQ_DEPTH - 1);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } fsm_t;

  // Control state
  fsm_t             fsm_q, fsm_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] uq_count_q, uq_count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             pred_valid_q, pred_valid_d;
  state_t           pred_state_q, pred_state_d;

  // Storage (no reset needed: the init sweep and FIFO pointers cover it)
  state_t           pht_q    [ENTRIES];
  logic [IDX_W-1:0] uq_idx_q [UQ_DEPTH];
  logic             uq_tkn_q [UQ_DEPTH];

  // Slot arbitration and table write port
  logic             run;
  logic             force_drain;
  logic             lk_grant;
  logic             up_enq;
  logic             drain;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  state_t           tbl_wdata;

  // Saturating counter step towards the resolved direction
  function automatic state_t sat_next(input state_t cur, input logic taken);
    logic [1:0] v;
    v = cur;
    if (taken) begin
      if (v != 2'b11) v = v + 2'd1;
    end else begin
      if (v != 2'b00) v = v - 2'd1;
    end
    return state_t'(v);
  endfunction

  assign head_idx   = uq_idx_q[rd_ptr_q];
  assign head_taken = uq_tkn_q[rd_ptr_q];

  // Decide who owns the table slot this cycle; lookups win unless a drain is forced
  always_comb begin
    run         = (fsm_q == S_RUN);
    force_drain = (uq_count_q == FULL_CNT) || (starve_q == STARVE_LIM);
    lk_ready    = run && !force_drain;
    up_ready    = run && (uq_count_q < FULL_CNT);
    lk_grant    = lk_valid && lk_ready;
    up_enq      = up_valid && up_ready;
    drain       = run && !lk_grant && (uq_count_q != '0);
  end

  // Update FIFO pointers, occupancy and the anti-starvation counter
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    uq_count_d = uq_count_q;
    starve_d   = starve_q;

    if (drain) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (up_enq) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    case ({up_enq, drain})
      2'b10:   uq_count_d = uq_count_q + CNT_W'(1);
      2'b01:   uq_count_d = uq_count_q - CNT_W'(1);
      default: uq_count_d = uq_count_q;
    endcase

    // Counts lookups that jumped ahead of a waiting update
    if (drain || (uq_count_q == '0)) begin
      starve_d = '0;
    end else if (lk_grant) begin
      starve_d = starve_q + SC_W'(1);
    end
  end

  // INIT sweep / RUN next-state and the table write port selection
  always_comb begin
    fsm_d      = fsm_q;
    init_ptr_d = init_ptr_q;
    tbl_we     = 1'b0;
    tbl_waddr  = head_idx;
    tbl_wdata  = sat_next(pht_q[head_idx], head_taken);

    case (fsm_q)
      S_INIT: begin
        tbl_we     = 1'b1;
        tbl_waddr  = init_ptr_q;
        tbl_wdata  = WNT;
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == LAST_IDX) fsm_d = S_RUN;
      end
      S_RUN: begin
        tbl_we = drain;
      end
      default: begin
        fsm_d = S_INIT;
      end
    endcase
  end

  // Prediction register: loads on an accepted lookup, otherwise holds
  always_comb begin
    pred_valid_d = lk_grant;
    pred_state_d = pred_state_q;
    if (lk_grant) pred_state_d = pht_q[lk_idx];
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q        <= S_INIT;
      init_ptr_q   <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      uq_count_q   <= '0;
      starve_q     <= '0;
      pred_valid_q <= 1'b0;
      pred_state_q <= WNT;
    end else begin
      fsm_q        <= fsm_d;
      init_ptr_q   <= init_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      uq_count_q   <= uq_count_d;
      starve_q     <= starve_d;
      pred_valid_q <= pred_valid_d;
      pred_state_q <= pred_state_d;
    end
  end

  // Table write: init sweep entry or drained read-modify-write result
  always_ff @(posedge clk) begin
    if (tbl_we) pht_q[tbl_waddr] <= tbl_wdata;
  end

  // FIFO entry write on enqueue
  always_ff @(posedge clk) begin
    if (up_enq) begin
      uq_idx_q[wr_ptr_q] <= up_idx;
      uq_tkn_q[wr_ptr_q] <= up_taken;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_state     = pred_state_q;
  assign pred_taken     = pred_state_q[1];
  assign init_done      = run;
  assign uq_count       = uq_count_q;
  assign dbg_state      = fsm_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_bp_pht_arbiter.sv
// Bench for bp_pht_arbiter: reference model of table, update FIFO and
// arbitration; predictions go through an expected queue.
module tb_bp_pht_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       lk_valid;
  logic       lk_ready;
  logic [3:0] lk_idx;
  logic       pred_valid;
  logic [1:0] pred_state;
  logic       pred_taken;
  logic       up_valid;
  logic       up_ready;
  logic [3:0] up_idx;
  logic       up_taken;
  logic       init_done;
  logic [2:0] uq_count;
  logic       dbg_state;
  logic [3:0] dbg_starve_cnt;

  always #5 clk = ~clk;

  bp_pht_arbiter #(.IDX_W(4), .UQ_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .lk_valid       (lk_valid),
    .lk_ready       (lk_ready),
    .lk_idx         (lk_idx),
    .pred_valid     (pred_valid),
    .pred_state     (pred_state),
    .pred_taken     (pred_taken),
    .up_valid       (up_valid),
    .up_ready       (up_ready),
    .up_idx         (up_idx),
    .up_taken       (up_taken),
    .init_done      (init_done),
    .uq_count       (uq_count),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- scoreboard / model state ----------------
  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [1:0] exp_q[$];

  logic [1:0] m_tbl [16];
  logic [3:0] mq_idx[$];
  logic       mq_taken[$];
  int         m_starve;
  bit         m_run;
  int         m_init_cnt;
  logic [1:0] m_pred_hold;

  logic [1:0] last_pred;
  logic       obs_lk_ready;
  logic       obs_up_ready;
  logic [2:0] obs_uq_count;
  logic [3:0] obs_starve;

  typedef struct {
    logic [3:0] idx;
    logic       taken;
    int         n;
    logic [1:0] exp_state;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] s, input logic t);
    if (t) return (s == 2'b11) ? 2'b11 : s + 2'd1;
    return (s == 2'b00) ? 2'b00 : s - 2'd1;
  endfunction

  task automatic model_reset();
    m_run       = 1'b0;
    m_init_cnt  = 0;
    m_starve    = 0;
    m_pred_hold = 2'b01;
    mq_idx.delete();
    mq_taken.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic cycle(input bit lv, input logic [3:0] li, input bit uv,
                       input logic [3:0] ui, input bit ut);
    bit fd, grant, enq, drain;
    int sz;
    logic [1:0] e;
    lk_valid = lv; lk_idx = li; up_valid = uv; up_idx = ui; up_taken = ut;
    #1;
    sz = mq_idx.size();
    fd = 0; grant = 0; enq = 0; drain = 0;
    if (m_run) begin
      fd    = (sz == 4) || (m_starve == 8);
      grant = lv && !fd;
      enq   = uv && (sz < 4);
      drain = !grant && (sz > 0);
    end
    check("lk_ready",   lk_ready, m_run && !fd);
    check("up_ready",   up_ready, m_run && (sz < 4));
    check("uq_count",   uq_count, sz);
    check("init_done",  init_done, m_run);
    check("fsm_state",  dbg_state, m_run);
    check("starve_cnt", dbg_starve_cnt, m_starve);
    obs_lk_ready = lk_ready;
    obs_up_ready = up_ready;
    obs_uq_count = uq_count;
    obs_starve   = dbg_starve_cnt;
    @(posedge clk);
    if (!m_run) begin
      m_init_cnt++;
      if (m_init_cnt == 16) m_run = 1'b1;
    end else begin
      if (grant) exp_q.push_back(m_tbl[li]);
      if (drain) begin
        m_tbl[mq_idx[0]] = sat(m_tbl[mq_idx[0]], mq_taken[0]);
        void'(mq_idx.pop_front());
        void'(mq_taken.pop_front());
      end
      if (drain || sz == 0) m_starve = 0;
      else if (grant) m_starve++;
      if (enq) begin
        mq_idx.push_back(ui);
        mq_taken.push_back(ut);
      end
    end
    @(negedge clk);
    if (grant) begin
      e = exp_q.pop_front();
      check("pred_valid", pred_valid, 1'b1);
      check("pred_state", pred_state, e);
      check("pred_taken", pred_taken, e[1]);
      m_pred_hold = e;
      last_pred   = pred_state;
    end else begin
      check("pred_valid_idle", pred_valid, 1'b0);
      check("pred_state_hold", pred_state, m_pred_hold);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'd0, 0, 4'd0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lk_ready"},   lk_ready, 1'b0);
    check({tag, "_up_ready"},   up_ready, 1'b0);
    check({tag, "_pred_valid"}, pred_valid, 1'b0);
    check({tag, "_pred_state"}, pred_state, 2'b01);
    check({tag, "_pred_taken"}, pred_taken, 1'b0);
    check({tag, "_init_done"},  init_done, 1'b0);
    check({tag, "_uq_count"},   uq_count, 3'd0);
    check({tag, "_starve"},     dbg_starve_cnt, 4'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int grants;
    vecs[0] = '{4'd3,  1'b1, 4, 2'b11};
    vecs[1] = '{4'd3,  1'b0, 5, 2'b00};
    vecs[2] = '{4'd9,  1'b1, 1, 2'b10};
    vecs[3] = '{4'd9,  1'b0, 1, 2'b01};
    vecs[4] = '{4'd0,  1'b0, 1, 2'b00};
    vecs[5] = '{4'd15, 1'b1, 2, 2'b11};
    vecs[6] = '{4'd15, 1'b0, 1, 2'b10};

    reset = 1'b1;
    lk_valid = 0; lk_idx = 0; up_valid = 0; up_idx = 0; up_taken = 0;
    last_pred = 2'b01;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;

    // Init sweep: 16 idle cycles, then ports live
    idle(16);
    #1;
    check("init_done_after_16", init_done, 1'b1);

    // First lookup of an initialised entry
    cycle(1, 4'd5, 0, 4'd0, 0);
    check("first_lookup_state", last_pred, 2'b01);
    check("first_lookup_taken", pred_taken, 1'b0);

    // Training vectors: n updates with no lookups, then read back
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < vecs[v].n; k++) cycle(0, 4'd0, 1, vecs[v].idx, vecs[v].taken);
      idle(2);
      cycle(1, vecs[v].idx, 0, 4'd0, 0);
      check($sformatf("vec%0d_state", v), last_pred, vecs[v].exp_state);
    end

    // Full FIFO under continuous lookups
    cycle(1, 4'd1, 1, 4'd2, 1);
    cycle(1, 4'd1, 1, 4'd4, 0);
    cycle(1, 4'd1, 1, 4'd6, 1);
    cycle(1, 4'd1, 1, 4'd8, 1);
    cycle(1, 4'd1, 1, 4'd12, 1);
    check("full_uq_count", obs_uq_count, 3'd4);
    check("full_up_ready", obs_up_ready, 1'b0);
    check("full_lk_ready", obs_lk_ready, 1'b0);
    cycle(1, 4'd1, 0, 4'd0, 0);
    check("after_full_count", obs_uq_count, 3'd3);
    check("after_full_lk_ready", obs_lk_ready, 1'b1);
    idle(6);

    // Starvation limit with one waiting update
    cycle(1, 4'd2, 1, 4'd10, 1);
    grants = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1, 4'(k), 0, 4'd0, 0);
      if (!obs_lk_ready) break;
      grants++;
    end
    check("starve_grants", grants, 8);
    cycle(1, 4'd10, 0, 4'd0, 0);
    check("starve_resume_ready", obs_lk_ready, 1'b1);
    check("starve_cleared", obs_starve, 4'd0);
    check("starve_drained_val", last_pred, 2'b10);
    idle(3);

    // Stale read: lookup and update of the same index in one cycle
    cycle(1, 4'd7, 1, 4'd7, 1);
    check("stale_read", last_pred, 2'b01);
    idle(2);
    cycle(1, 4'd7, 0, 4'd0, 0);
    check("post_drain_read", last_pred, 2'b10);

    // Random traffic against the model
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
    end
    idle(8);

    // Reset with three queued updates
    cycle(1, 4'd0, 1, 4'd3, 1);
    cycle(1, 4'd0, 1, 4'd3, 1);
    cycle(1, 4'd0, 1, 4'd3, 1);
    check("pre_reset_count", obs_uq_count, 3'd2);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst1");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Requests during init are ignored
    for (int k = 0; k < 16; k++) cycle(1, 4'd3, 1, 4'd3, 1);
    #1;
    check("reinit_done", init_done, 1'b1);
    cycle(1, 4'd3, 0, 4'd0, 0);
    check("reinit_idx3", last_pred, 2'b01);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
